imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter IMEM_WORDS, default 1024, meaning the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width, equal to clog2(IMEM_WORDS).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-004 The block SHALL have port resetn, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a single-cycle request to begin a load.
REQ-006 The block SHALL have port num_words, input, ADDR_W+1, the number of words to load, sampled on start.
REQ-007 The block SHALL have port in_valid, input, 1, which indicates that the byte-stream data is valid.
REQ-008 The block SHALL have port in_data, input, 8, the program byte.
REQ-009 The block SHALL have port in_ready, output, 1, which indicates that the loader accepts a byte.
REQ-010 The block SHALL have port mem_we, output, 1, the instruction-memory write enable.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W, the word address.
REQ-012 The block SHALL have port mem_wdata, output, 32, the instruction word.
REQ-013 The block SHALL have port busy, output, 1, which indicates that a load is in progress.
REQ-014 The block SHALL have port done, output, 1, which indicates that the last load completed successfully.
REQ-015 The block SHALL have port error, output, 1, which indicates that the last start was rejected.
REQ-016 The block SHALL have port cpu_resetn, output, 1, the active-low reset to the core, released only after a successful load.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, DONE and ERR.
REQ-018 On start with 1 <= num_words <= IMEM_WORDS, the block SHALL move from IDLE, DONE or ERR to LOAD, clear the word and byte counters, and set cpu_resetn to 0.
REQ-019 On start with num_words = 0 or num_words > IMEM_WORDS, the block SHALL move to ERR, perform no writes, and set error to 1.
REQ-020 The block SHALL ignore start while in LOAD.
REQ-021 The block SHALL drive in_ready to 1 exactly when the state is LOAD.
REQ-022 The block SHALL accept a byte on any cycle where in_valid and in_ready are both 1.
REQ-023 The block SHALL pack the accepted bytes little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-024 The cycle after the 4th byte of a word is accepted, the block SHALL drive mem_we=1 for exactly one cycle, with mem_addr equal to the word index starting at 0 and mem_wdata equal to the packed word (latency 1 cycle).
REQ-025 The block SHALL allow byte acceptance to continue during the mem_we cycle, so the stream can run at 1 byte per cycle without stalls.
REQ-026 The cycle after the 4th byte of word num_words-1 is accepted, the block SHALL move to DONE; in_ready SHALL be 0 from that cycle on.
REQ-027 On the final mem_we cycle, the block SHALL set done=1 and cpu_resetn=1, both registered and in the same cycle.
REQ-028 The block SHALL hold the outputs as follows in each state:
- LOAD: busy=1, done=0, error=0.
- DONE: busy=0, done=1, cpu_resetn=1.
- ERR: busy=0, error=1, cpu_resetn=0.
REQ-029 In states other than LOAD, the block SHALL ignore in_valid and SHALL drop no accepted bytes.
REQ-030 The word counter SHALL NOT wrap; the maximum address written SHALL be num_words-1.
REQ-031 When mem_we=0, mem_addr and mem_wdata SHALL hold their last values.

Reset
REQ-032 When resetn is 0, the block SHALL asynchronously force the following values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_resetn=0, and all counters to 0.
REQ-033 A reset during LOAD SHALL abandon the partial word with no further write; the memory contents already written are not restored.
REQ-034 The release of resetn SHALL take effect at the next rising clk edge.

Structure
REQ-035 The package imem_loader_pkg SHALL hold the state enum type, IMEM_WORDS_DEFAULT and the function computing ADDR_W.
REQ-036 The sub-module byte_packer SHALL handle the 2-bit byte counter, the 32-bit shift/assembly register and a word_valid pulse; imem_loader SHALL own the FSM, the word counter and the memory port.

Verification
REQ-037 Directed test: start with num_words=2, then bytes 13 00 00 00 93 00 10 00 back-to-back -> mem_we at addr 0 with data 0x00000013, then at addr 1 with data 0x00100093; done=1 and cpu_resetn=1 together with the second write.
REQ-038 Directed test: start with num_words=1 and in_valid toggled randomly -> exactly one write, with data assembled from the four accepted bytes in order.
REQ-039 Directed test: start with num_words=0, then separately with num_words=1025 -> ERR, error=1, no mem_we, in_ready=0.
REQ-040 Directed test: assert resetn=0 after 6 bytes of a 4-word load -> outputs at reset values immediately, only the write to addr 0 has occurred; start with num_words=1 after release loads at addr 0.
REQ-041 Directed test: start pulsed during LOAD with num_words=5 -> ignored; the original count is completed.
REQ-042 Directed test: start from DONE with num_words=1024 -> cpu_resetn=0 during the reload, and the final write is at addr 1023 with no wrap.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
package imem_loader_pkg;
  localparam int IMEM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  function automatic int addr_w_of(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian 32-bit words from an accepted byte stream.
module byte_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  cnt;
  logic [23:0] asm_q;  // only three bytes are stored; the fourth arrives with word_valid

  assign word_valid = accept && (cnt == 2'd3);
  assign word       = {in_byte, asm_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (clr) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (accept) begin
      cnt   <= cnt + 2'd1;
      asm_q <= {in_byte, asm_q[23:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, holding the core in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int ADDR_W     = addr_w_of(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_resetn
);
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(IMEM_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   nwords;
  logic [ADDR_W-1:0] wcnt;
  logic              num_ok, load_go, load_bad, accept, last_word, word_valid;
  logic [31:0]       word;

  assign num_ok    = (num_words != '0) && (num_words <= MAX_WORDS);
  assign load_go   = start && (state != LOAD) && num_ok;
  assign load_bad  = start && (state != LOAD) && !num_ok;
  assign accept    = in_valid && (state == LOAD);
  assign last_word = ({1'b0, wcnt} == (nwords - 1'b1));

  // Status outputs decode the state register, so they are glitch-free and reset asynchronously.
  assign in_ready   = (state == LOAD);
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign cpu_resetn = (state == DONE);

  byte_packer u_packer (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (load_go),
    .accept    (accept),
    .in_byte   (in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (word_valid && last_word) state_nxt = DONE;
      default: begin
        if (load_go)       state_nxt = LOAD;
        else if (load_bad) state_nxt = ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      nwords    <= '0;
      wcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= word_valid;
      if (load_go) begin
        nwords <= num_words;
        wcnt   <= '0;
      end
      if (word_valid) begin
        mem_addr  <= wcnt;
        mem_wdata <= word;
        // Saturate on the last word so the address never wraps.
        if (!last_word) wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule
